ram_arb_rr: RTL and testbench
=============================

RAM_ARB_RR -- requirements
Module: ram_arb_rr

Interface
REQ-001 SHALL have parameters: WIDTH, 8, data word width; DEPTH, 64, RAM word count; LG_DEPTH, 6, address width (DEPTH = 2**LG_DEPTH); INIT_VAL, 8'd0, clear-sweep fill value.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all logic posedge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  requester N (N = 0, 1) access request.
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  LG_DEPTH  access address.
- reqN_wdata  in  WIDTH  write data.
- rspN_valid  out  1  read data valid for requester N.
- rspN_rdata  out  WIDTH  read data, equal to ram_dout.
- clear  in  1  request re-clear of whole RAM.
- busy  out  1  clear sweep in progress.
- ram_en, ram_we  out  1  RAM port enable and write enable.
- ram_addr  out  LG_DEPTH  RAM address.
- ram_din  out  WIDTH  RAM write data.
- ram_dout  in  WIDTH  RAM read data, registered, 1-cycle latency.

Function
REQ-003 SHALL implement FSM states CLEAR and SERVE.
REQ-004 In CLEAR: ram_en=1, ram_we=1, ram_addr=clr_cnt, ram_din=INIT_VAL, both reqN_ready=0, busy=1; clr_cnt increments by 1 each cycle.
REQ-005 CLEAR -> SERVE after the cycle with clr_cnt = DEPTH-1, i.e. exactly DEPTH write cycles; clr_cnt wraps to 0.
REQ-006 In SERVE with clear=1: no grant that cycle (both ready=0, ram_en=0); next state CLEAR with clr_cnt=0.
REQ-007 In SERVE with clear=0, one grant per cycle, combinational: only one valid -> grant it; both valid -> grant requester != last_grant.
REQ-008 last_grant register SHALL update to the granted index only on a grant cycle.
REQ-009 Granted requester: reqN_ready=1; ram_en=1, ram_we=reqN_we, ram_addr=reqN_addr, ram_din=reqN_wdata.
REQ-010 No grant: ram_en=0, ram_we=0; ram_addr and ram_din are don't-care.
REQ-011 rspN_valid SHALL be registered, high exactly one cycle after a granted read by N, never after writes; rspN_rdata valid only when rspN_valid=1.
REQ-012 A response for a read granted in the cycle clear is sampled SHALL still be delivered (REQ-006 blocks that grant, so none exists); a read granted the cycle before CLEAR entry SHALL deliver rsp in the first CLEAR cycle.
REQ-013 No response backpressure; requesters hold valid/we/addr/wdata stable until ready.
REQ-014 Same-address write by one requester and read by the other in consecutive cycles SHALL return ordered (post-write) data per RAM read-first semantics of that cycle.
REQ-015 busy SHALL be registered-state derived (state==CLEAR), no combinational path from clear.

Reset
REQ-016 On rst_n=0, asynchronously: rsp0_valid=0, rsp1_valid=0, clr_cnt=0, last_grant=1 (requester 0 wins first tie).
REQ-017 Reset state SHALL be CLEAR when RAM_ARB_CLEAR_EN defined, SERVE otherwise; busy follows state.
REQ-018 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.

Configuration
REQ-019 Macro RAM_ARB_CLEAR_EN: defined -> CLEAR state, clr_cnt, INIT_VAL sweep, clear input all active; undefined -> FSM fixed in SERVE, clear ignored, busy tied 0, no clr_cnt logic.

Verification
REQ-020 CLEAR_EN defined, release rst_n, both valid=1 -> busy=1 for 64 cycles, ram_addr 0..63, ram_din=0, no ready; cycle 65 req0_ready=1.
REQ-021 Both requesters hold read valid continuously (req0 addr 5, req1 addr 9) -> grants alternate 0,1,0,1; rsp0/rsp1 valid alternate one cycle later.
REQ-022 req0 write addr 3 data 8'hA5, next cycle req1 read addr 3 -> rsp1_valid with rspN_rdata=8'hA5.
REQ-023 clear pulsed with req1 valid in SERVE -> req1_ready=0 that cycle, busy=1 next 64 cycles, then req1 granted; prior rsp still delivered.
REQ-024 CLEAR_EN undefined, reset release -> busy=0, req0 read granted in first cycle, clear=1 has no effect.
REQ-025 rst_n asserted at clr_cnt=30 -> rsp valids 0 immediately; after release sweep restarts at ram_addr=0.

Source files
------------

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-requester round-robin arbiter in front of a single-port RAM (1-cycle read latency).
// Define RAM_ARB_CLEAR_EN to enable the INIT_VAL clear sweep at reset and on the clear input.
module ram_arb_rr #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 64,
  parameter int               LG_DEPTH = 6,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_we,
  input  logic [LG_DEPTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]    req0_wdata,
  output logic                rsp0_valid,
  output logic [WIDTH-1:0]    rsp0_rdata,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_we,
  input  logic [LG_DEPTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]    req1_wdata,
  output logic                rsp1_valid,
  output logic [WIDTH-1:0]    rsp1_rdata,
  input  logic                clear,
  output logic                busy,
  output logic                ram_en,
  output logic                ram_we,
  output logic [LG_DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0]    ram_din,
  input  logic [WIDTH-1:0]    ram_dout
);

  localparam logic [0:0]          S_CLEAR   = 1'b0;
  localparam logic [0:0]          S_SERVE   = 1'b1;
  localparam logic [LG_DEPTH-1:0] LAST_ADDR = LG_DEPTH'(DEPTH - 1);

  logic [0:0]          w_state;
  logic [LG_DEPTH-1:0] w_clr_addr;
  logic                w_clear_req;
  logic                w_serve;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                r_last_grant;
  logic                r_rsp0_valid;
  logic                r_rsp1_valid;

`ifdef RAM_ARB_CLEAR_EN
  logic [0:0]          r_state;
  logic [LG_DEPTH-1:0] r_clr_cnt;

  // Sweep writes every address once; the counter wraps to 0 on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + LG_DEPTH'(1);
      if (r_clr_cnt == LAST_ADDR) begin
        r_state <= S_SERVE;
      end
    end else if (clear) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end
  end

  assign w_state     = r_state;
  assign w_clr_addr  = r_clr_cnt;
  assign w_clear_req = clear;
`else
  logic [LG_DEPTH:0] w_unused_cfg;

  assign w_state      = S_SERVE;
  assign w_clr_addr   = '0;
  assign w_clear_req  = 1'b0;
  assign w_unused_cfg = {clear, LAST_ADDR};
`endif

  // r_last_grant = 1 means requester 1 won the last grant, so requester 0 wins a tie.
  assign w_serve = (w_state == S_SERVE) && !w_clear_req;
  assign w_gnt0  = w_serve && req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1  = w_serve && req1_valid && (!req0_valid || !r_last_grant);

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_state == S_CLEAR) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = w_clr_addr;
      ram_din  = INIT_VAL;
    end else if (w_gnt0) begin
      ram_en   = 1'b1;
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_din  = req0_wdata;
    end else if (w_gnt1) begin
      ram_en   = 1'b1;
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_din  = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_last_grant <= 1'b1;
      end
      r_rsp0_valid <= w_gnt0 && !req0_we;
      r_rsp1_valid <= w_gnt1 && !req1_we;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = ram_dout;
  assign rsp1_rdata = ram_dout;
  assign busy       = (w_state == S_CLEAR);

endmodule

// File: tb/tb_ram_arb_rr.sv
// Self-checking bench for ram_arb_rr: external RAM model plus a transaction-level arbitration/memory reference.
module tb_ram_arb_rr;
  localparam int         WIDTH    = 8;
  localparam int         DEPTH    = 64;
  localparam int         LG_DEPTH = 6;
  localparam logic [7:0] INIT_VAL = 8'd0;
`ifdef RAM_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [LG_DEPTH-1:0] req0_addr;
  logic [WIDTH-1:0]    req0_wdata, rsp0_rdata;
  logic                req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [LG_DEPTH-1:0] req1_addr;
  logic [WIDTH-1:0]    req1_wdata, rsp1_rdata;
  logic                clear, busy, ram_en, ram_we;
  logic [LG_DEPTH-1:0] ram_addr;
  logic [WIDTH-1:0]    ram_din, ram_dout;

  ram_arb_rr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .clear(clear), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Read-first single-port RAM with registered output.
  logic [WIDTH-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
  end

  // Reference state: memory contents, who was served last, sweep progress, pending responses.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int               m_last;
  int               m_clr;
  bit               exp_v0, exp_v1;
  logic [WIDTH-1:0] exp_d0, exp_d1;
  int               n_checks, n_fail, cyc;

  task automatic model_reset();
    m_last = 1;
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    m_clr  = CLEAR_EN ? 0 : -1;
  endtask

  // One clock cycle: check everything at the falling edge, advance the reference, return at posedge+1.
  task automatic step(output int obs);
    int                  g;
    logic                gwe;
    logic [LG_DEPTH-1:0] ga;
    logic [WIDTH-1:0]    gd;
    @(negedge clk);
    g = -1;
    if (m_clr < 0 && !(CLEAR_EN && clear)) begin
      if (req0_valid && req1_valid) g = 1 - m_last;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    obs = (req0_ready && req1_ready) ? 2 : req0_ready ? 0 : req1_ready ? 1 : -1;
    if (g == 1) begin gwe = req1_we; ga = req1_addr; gd = req1_wdata; end
    else begin gwe = req0_we; ga = req0_addr; gd = req0_wdata; end

    n_checks++;
    if (obs != g) begin n_fail++; $display("FAIL grant cyc %0d: got %0d want %0d", cyc, obs, g); end
    n_checks++;
    if (busy !== (m_clr >= 0)) begin n_fail++; $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, m_clr >= 0); end
    n_checks++;
    if (ram_en !== (g >= 0 || m_clr >= 0)) begin n_fail++; $display("FAIL ram_en cyc %0d: got %b want %b", cyc, ram_en, (g >= 0 || m_clr >= 0)); end
    if (m_clr >= 0) begin
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== LG_DEPTH'(m_clr) || ram_din !== INIT_VAL) begin
        n_fail++;
        $display("FAIL sweep cyc %0d: got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h", cyc, ram_we, ram_addr, ram_din, m_clr, INIT_VAL);
      end
    end else if (g >= 0) begin
      n_checks++;
      if (ram_we !== gwe || ram_addr !== ga || (gwe && ram_din !== gd)) begin
        n_fail++;
        $display("FAIL ram_port cyc %0d: got we=%b addr=%0d din=%h want we=%b addr=%0d din=%h", cyc, ram_we, ram_addr, ram_din, gwe, ga, gd);
      end
    end else begin
      n_checks++;
      if (ram_we !== 1'b0) begin n_fail++; $display("FAIL ram_we_idle cyc %0d: got %b want 0", cyc, ram_we); end
    end
    n_checks++;
    if (rsp0_valid !== exp_v0) begin n_fail++; $display("FAIL rsp0_valid cyc %0d: got %b want %b", cyc, rsp0_valid, exp_v0); end
    n_checks++;
    if (rsp1_valid !== exp_v1) begin n_fail++; $display("FAIL rsp1_valid cyc %0d: got %b want %b", cyc, rsp1_valid, exp_v1); end
    if (exp_v0) begin
      n_checks++;
      if (rsp0_rdata !== exp_d0) begin n_fail++; $display("FAIL rsp0_rdata cyc %0d: got %h want %h", cyc, rsp0_rdata, exp_d0); end
    end
    if (exp_v1) begin
      n_checks++;
      if (rsp1_rdata !== exp_d1) begin n_fail++; $display("FAIL rsp1_rdata cyc %0d: got %h want %h", cyc, rsp1_rdata, exp_d1); end
    end
    $display("cyc %0d: grant=%0d we=%b addr=%0d busy=%b rsp0=%b rsp1=%b", cyc, g, gwe, ga, busy, rsp0_valid, rsp1_valid);

    exp_v0 = (g == 0) && !gwe;
    exp_v1 = (g == 1) && !gwe;
    exp_d0 = ref_mem[ga];
    exp_d1 = ref_mem[ga];
    if (g >= 0) begin
      if (gwe) ref_mem[ga] = gd;
      m_last = g;
    end
    if (m_clr >= 0) begin
      ref_mem[m_clr] = INIT_VAL;
      m_clr++;
      if (m_clr == DEPTH) m_clr = -1;
    end else if (CLEAR_EN && clear) begin
      m_clr = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic we, input logic [LG_DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    if (k == 0) begin req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; end
    else begin req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; end
  endtask

  task automatic new_req(input int k);
    set_req(k, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), LG_DEPTH'($urandom_range(0, 7)), WIDTH'($urandom));
  endtask

  task automatic run_sweep();
    int obs;
    for (int i = 0; i < DEPTH + 1 && m_clr >= 0; i++) step(obs);
  endtask

  task automatic test_reset();
    int obs;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    clear = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (busy !== CLEAR_EN) begin n_fail++; $display("FAIL reset_busy: got %b want %b", busy, CLEAR_EN); end
    n_checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %b%b want 00", rsp0_valid, rsp1_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    set_req(1, 1'b1, 1'b0, 6'd9, '0);
    run_sweep();
    step(obs);
    n_checks++;
    if (obs != 0) begin n_fail++; $display("FAIL first_grant: got %0d want 0", obs); end
  endtask

  task automatic test_fill();
    int obs;
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int a = 0; a < DEPTH; a++) begin
      set_req(0, 1'b1, 1'b1, LG_DEPTH'(a), WIDTH'($urandom));
      step(obs);
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_alternate();
    int obs, prev;
    set_req(0, 1'b1, 1'b0, 6'd5, '0);
    set_req(1, 1'b1, 1'b0, 6'd9, '0);
    step(prev);
    for (int i = 0; i < 8; i++) begin
      step(obs);
      n_checks++;
      if (obs == prev || obs < 0 || obs > 1) begin n_fail++; $display("FAIL alternate step %0d: got %0d want %0d", i, obs, 1 - prev); end
      prev = obs;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step(obs);
  endtask

  task automatic test_write_read();
    int obs;
    set_req(0, 1'b1, 1'b1, 6'd3, 8'hA5);
    step(obs);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 6'd3, '0);
    step(obs);
    set_req(1, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (rsp1_valid !== 1'b1 || rsp1_rdata !== 8'hA5) begin n_fail++; $display("FAIL write_read: got v=%b d=%h want v=1 d=a5", rsp1_valid, rsp1_rdata); end
    step(obs);
  endtask

  task automatic test_clear();
    int obs;
    set_req(0, 1'b1, 1'b0, 6'd7, '0);
    step(obs);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 6'd9, '0);
    clear = 1'b1;
    step(obs);
    clear = 1'b0;
    n_checks++;
    if (obs != (CLEAR_EN ? -1 : 1)) begin n_fail++; $display("FAIL clear_cycle_grant: got %0d want %0d", obs, CLEAR_EN ? -1 : 1); end
    run_sweep();
    step(obs);
    n_checks++;
    if (obs != 1) begin n_fail++; $display("FAIL after_clear_grant: got %0d want 1", obs); end
    set_req(1, 1'b0, 1'b0, '0, '0);
    step(obs);
  endtask

  task automatic test_random(input int n);
    int obs;
    new_req(0);
    new_req(1);
    for (int i = 0; i < n; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      step(obs);
      if (obs == 0 || !req0_valid) new_req(0);
      if (obs == 1 || !req1_valid) new_req(1);
    end
    clear = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    run_sweep();
    step(obs);
  endtask

  task automatic test_async_reset();
    int obs;
    set_req(0, 1'b1, 1'b0, 6'd2, '0);
    step(obs);
    set_req(0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if (rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rsp0: got %b want 1", rsp0_valid); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_rsp: got %b%b want 00", rsp0_valid, rsp1_valid); end
    @(posedge clk);
    #1 rst_n = 1'b1;
`ifdef RAM_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH && m_clr != 30; i++) step(obs);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_sweep_busy: got %b want 1", busy); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    n_checks++;
    if (ram_addr !== '0) begin n_fail++; $display("FAIL sweep_restart_addr: got %0d want 0", ram_addr); end
`endif
    run_sweep();
    set_req(0, 1'b1, 1'b0, 6'd4, '0);
    set_req(1, 1'b1, 1'b0, 6'd6, '0);
    step(obs);
    n_checks++;
    if (obs != 0) begin n_fail++; $display("FAIL post_reset_tie: got %0d want 0", obs); end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step(obs);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_fill();
    test_alternate();
    test_write_read();
    test_clear();
    test_random(400);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
